// File: rtl/som_sweep_ctrl.sv
// som_sweep_ctrl: walks a 4-input sum-of-minterms block through all 16
// input combinations. Each combination settles for SETTLE_CYCLES cycles,
// then F is sampled and compared against a latched expected truth table.
module som_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        F,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic        fail_valid,
  output logic [3:0]  fail_idx,
  output logic [15:0] captured
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] cap_q, cap_d;
  logic [4:0]  err_q, err_d;
  logic        fv_q, fv_d;
  logic [3:0]  fidx_q, fidx_d;
  logic        pass_q, pass_d;

  // State register and sweep bookkeeping, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fidx_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fidx_q  <= fidx_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic: settle countdown, sample/compare, abort handling
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    cap_d   = cap_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fidx_d  = fidx_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d   = expected;
          idx_d   = '0;
          cnt_d   = '0;
          cap_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fidx_d  = '0;
          pass_d  = 1'b0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == SETTLE_LAST) begin
            state_d = S_SAMPLE;
          end
        end
      end
      S_SAMPLE: begin
        // An abort here drops the sample: results keep only earlier minterms
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cap_d[idx_q] = F;
          if (F != exp_q[idx_q]) begin
            err_d = err_q + 5'd1;
            if (!fv_q) begin
              fv_d   = 1'b1;
              fidx_d = idx_q;
            end
          end
          if (idx_q == 4'd15) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        pass_d  = (err_q == 5'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    {A, B, C, D} = (state_q == S_IDLE) ? 4'b0000 : idx_q;
  end

  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_idx   = fidx_q;
  assign captured   = cap_q;

endmodule

// File: tb/tb_som_sweep_ctrl.sv
// Bench for som_sweep_ctrl: two instances (settle 2 and settle 1) share
// control inputs; each drives its own table-lookup SOM model. Expected
// outputs come from a cycle-indexed model of the sweep schedule.
module tb_som_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic [15:0] tbl;

  logic        f_i      [2];
  logic        a_o      [2];
  logic        b_o      [2];
  logic        c_o      [2];
  logic        d_o      [2];
  logic        busy_o   [2];
  logic        done_o   [2];
  logic        pass_o   [2];
  logic [4:0]  err_o    [2];
  logic        fv_o     [2];
  logic [3:0]  fidx_o   [2];
  logic [15:0] cap_o    [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int          sv    [2] = '{2, 1};
  int          sw    [2];
  int          nfix  [2];
  logic [15:0] exl   [2];
  logic [15:0] tbl_l [2];

  assign f_i[0] = tbl[{a_o[0], b_o[0], c_o[0], d_o[0]}];
  assign f_i[1] = tbl[{a_o[1], b_o[1], c_o[1], d_o[1]}];

  som_sweep_ctrl #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .F(f_i[0]),
    .A(a_o[0]), .B(b_o[0]), .C(c_o[0]), .D(d_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .err_count(err_o[0]), .fail_valid(fv_o[0]), .fail_idx(fidx_o[0]),
    .captured(cap_o[0])
  );

  som_sweep_ctrl #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .F(f_i[1]),
    .A(a_o[1]), .B(b_o[1]), .C(c_o[1]), .D(d_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .err_count(err_o[1]), .fail_valid(fv_o[1]), .fail_idx(fidx_o[1]),
    .captured(cap_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int u, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s[u%0d] cyc=%0d observed=%0h expected=%0h",
             tag, u, cyc, obs, expv);
    end
  endtask

  // Advance one clock edge; the model decides what each instance accepts
  task automatic step();
    for (int u = 0; u < 2; u++) begin
      int rel;
      bit act;
      bit idle;
      rel  = cyc - sw[u];
      act  = (sw[u] >= 0) && (rel >= 1) && (rel <= 16 * (sv[u] + 1));
      idle = (sw[u] < 0) || (rel > 16 * (sv[u] + 1) + 1);
      if (!rst_n) begin
        sw[u]   = -1;
        nfix[u] = 0;
      end else if (idle && start) begin
        sw[u]    = cyc;
        exl[u]   = expected;
        tbl_l[u] = tbl;
      end else if (act && abort) begin
        nfix[u] = (rel - 1) / (sv[u] + 1);
        sw[u]   = -1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Compare every output of both instances against the schedule model
  task automatic check_all();
    for (int u = 0; u < 2; u++) begin
      int s, rel, n, fi;
      bit act, dn;
      logic [15:0] mask, mism;
      s   = sv[u];
      rel = cyc - sw[u];
      act = (sw[u] >= 0) && (rel >= 1) && (rel <= 16 * (s + 1));
      dn  = (sw[u] >= 0) && (rel == 16 * (s + 1) + 1);
      if (sw[u] >= 0) begin
        n = (rel - 1) / (s + 1);
        if (n > 16) n = 16;
      end else begin
        n = nfix[u];
      end
      mask = (n >= 16) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
      mism = (tbl_l[u] ^ exl[u]) & mask;
      fi = 0;
      for (int i = 15; i >= 0; i--) if (mism[i]) fi = i;
      chk("busy", u, busy_o[u], act || dn);
      chk("done", u, done_o[u], dn);
      if (!dn) chk("abcd", u, {a_o[u], b_o[u], c_o[u], d_o[u]},
                   act ? (rel - 1) / (s + 1) : 0);
      chk("pass", u, pass_o[u],
          (sw[u] >= 0) && (rel >= 16 * (s + 1) + 2) && (mism == 16'h0));
      chk("err_count", u, err_o[u], $countones(mism));
      chk("fail_valid", u, fv_o[u], mism != 16'h0);
      chk("fail_idx", u, fidx_o[u], fi);
      chk("captured", u, cap_o[u], tbl_l[u] & mask);
    end
  endtask

  // Launch a sweep (start sampled at this edge) and run len checked cycles
  task automatic run(input int len, input int st_from, input int st_to,
                     input int abort_at, input int rst_at);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= len; k++) begin
      start = (k >= st_from) && (k <= st_to);
      abort = (k == abort_at);
      rst_n = !(k == rst_at);
      check_all();
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      sw[u]    = -1;
      nfix[u]  = 0;
      exl[u]   = '0;
      tbl_l[u] = '0;
    end
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    expected = '0;
    tbl      = '0;
    step();
    step();
    rst_n = 1'b1;
    check_all();

    // Matching table: clean pass on both settle lengths
    expected = 16'hA5C3;
    tbl      = 16'hA5C3;
    run(60, 0, 0, 0, 0);
    chk("t1_pass", 0, pass_o[0], 1);
    chk("t1_captured", 0, cap_o[0], 16'hA5C3);
    chk("t1_captured", 1, cap_o[1], 16'hA5C3);

    // Two flipped minterms (2 and 8)
    tbl = 16'hA5C3 ^ 16'h0104;
    run(60, 0, 0, 0, 0);
    for (int u = 0; u < 2; u++) begin
      chk("t2_err", u, err_o[u], 2);
      chk("t2_fidx", u, fidx_o[u], 2);
      chk("t2_pass", u, pass_o[u], 0);
      chk("t2_captured", u, cap_o[u], 16'hA4C7);
    end

    // Mid-sweep start ignored, held start relaunches after DONE
    expected = 16'($urandom);
    tbl      = expected ^ 16'($urandom & $urandom & $urandom);
    run(110, 20, 52, 0, 0);

    // Abort while the settle-2 instance drives minterm 7
    expected = 16'($urandom);
    tbl      = expected ^ 16'($urandom & $urandom);
    run(60, 0, 0, 22, 0);
    chk("t4_pass", 0, pass_o[0], 0);

    // Reset pulse while the settle-2 instance drives minterm 9
    expected = 16'($urandom);
    tbl      = expected ^ 16'($urandom & $urandom);
    run(60, 0, 0, 0, 29);

    // Random table, full sweep after the reset
    expected = 16'($urandom);
    tbl      = expected ^ 16'($urandom & $urandom & $urandom);
    run(60, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/som_sweep_ctrl.md
# som_sweep_ctrl

Sequencing controller for the 4-input sum-of-minterms block (inputs A, B, C, D; output F). On a start pulse it walks the SOM block through all 16 input combinations in minterm order (0000 to 1111). It lets each combination settle for a programmable number of cycles, samples F, and compares it against a 16-bit expected truth table. This is the on-chip equivalent of the exhaustive sweep bench: it sits between the board-level control (switch/button logic) and the SOM datapath, and reports pass/fail, error count and first failing minterm.

## Interface
- SETTLE_CYCLES, 2, clock cycles each input combination is held before F is sampled (legal range 1 to 15)
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin a sweep; sampled only in IDLE
- abort  input  1  cancel a sweep in progress; ignored in IDLE
- expected  input  16  required F per minterm; bit i corresponds to {A,B,C,D} = i; latched at start
- F  input  1  output of the SOM block under control
- A, B, C, D  output  1 each  drive to the SOM block; {A,B,C,D} = current minterm index, A = MSB
- busy  output  1  high from the cycle after start until DONE is exited
- done  output  1  one-cycle pulse on sweep completion (not asserted on abort)
- pass  output  1  err_count == 0 for the last completed sweep; held until next start
- err_count  output  5  number of mismatching minterms, 0 to 16
- fail_valid  output  1  at least one mismatch recorded
- fail_idx  output  4  lowest minterm index that mismatched; valid when fail_valid
- captured  output  16  sampled F values; bit i = F observed at minterm i

## Operation
- Reset (rst_n low at a clk edge): state IDLE, {A,B,C,D}=0000, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_idx=0, captured=0. Reset overrides start and abort.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: {A,B,C,D}=0000, busy=0. When start=1, the block latches expected, sets idx=0, and clears captured, err_count, fail_valid, fail_idx and pass. It loads settle counter=0 and moves to SETTLE.
- SETTLE: {A,B,C,D}=idx. The counter increments each cycle. After SETTLE_CYCLES cycles in SETTLE, the next state is SAMPLE.
- SAMPLE: {A,B,C,D}=idx is still driven, and the block samples F.
  - It writes captured[idx]=F.
  - On F != expected_latched[idx], err_count increments. If fail_valid=0, the block sets fail_valid=1 and fail_idx=idx.
  - If idx==15, the next state is DONE. Otherwise idx increments, the counter clears, and the next state is SETTLE.
- DONE: done=1 and busy=1 for exactly one cycle. pass=(err_count==0) is registered here. The next state is IDLE.
- abort=1 in SETTLE or SAMPLE: the next state is IDLE and done is not pulsed. On abort, captured, err_count and fail_* keep their partial values and pass remains 0. An abort in the same cycle as a SAMPLE discards that sample.
- start while not IDLE: ignored. start held high continuously begins a new sweep on the first IDLE cycle after DONE.
- err_count width: 5 bits so that 16 mismatches is representable without wrap.

## Timing
- Cycle 0 = the edge at which start is sampled in IDLE. busy is high from cycle 1. idx=0 is driven from cycle 1.
- Each minterm occupies SETTLE_CYCLES+1 cycles (SETTLE then SAMPLE). Minterm i is driven during cycles i(S+1)+1 through (i+1)(S+1).
- The done pulse occurs at cycle 16(S+1)+1. With the default S=2 this is cycle 49. busy falls and the block is back in IDLE at cycle 16(S+1)+2.
- Results (pass, err_count, fail_*, captured) are stable from the cycle after done until the next accepted start.
- The earliest next sweep starts with start sampled at cycle 16(S+1)+2.
- F is assumed combinational from A..D. Settle timing is satisfied because {A,B,C,D} is held at least one full cycle before SAMPLE.

## Test plan
- A bench model drives F = table[{A,B,C,D}] with table=expected=16'hA5C3, S=2. Required response: done at cycle 49, pass=1, err_count=0, fail_valid=0, captured=16'hA5C3.
- Same setup, but table=16'hA5C3^16'h0104. Required response: err_count=2, fail_valid=1, fail_idx=2, pass=0, captured=16'hA4C7.
- Pulse start again at cycle 20 and hold start high. Required response: the mid-sweep start is ignored, the sweep completes at cycle 49, and a second sweep begins at cycle 50.
- Assert abort while idx=7. Required response: busy=0 and {A,B,C,D}=0000 the next cycle, done is never asserted, and pass=0.
- Drive rst_n low for one cycle at idx=9. Required response: all outputs at their reset values after that edge, and the state is IDLE.
- Set SETTLE_CYCLES=1. Required response: {A,B,C,D} steps 0000 to 1111 with each value held 2 cycles, and done occurs at cycle 33.
